// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: per-stage payload/control structs and their widths,
// plus a pointer-width helper used by the elastic stage buffers.
package cpu_types_pkg;

  // MEM/WB payload carried through the stage buffer as opaque bits.
  typedef struct packed {
    logic [31:0] dmemload;
    logic [31:0] alu_out;
    logic [31:0] addr;
    logic [26:0] npc;
    logic [4:0]  wsel;
  } mem_wb_data_t;

  // MEM/WB control bits; these are zeroed by the buffer when its output is invalid.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic halt;
    logic lui;
  } mem_wb_ctrl_t;

  localparam int MEM_WB_DATA_W = $bits(mem_wb_data_t);
  localparam int MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);

  // Pointer width for a circular buffer; at least one bit even when depth is 1.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pl_ptr_ctr.sv
// Wrap-around pointer: counts 0..DEPTH-1 on inc, returns to 0 on clr.
module pl_ptr_ctr #(
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  localparam logic [W-1:0] LAST = W'(DEPTH - 1);

  // Pointer register: clear wins over increment, wrap after the last entry.
  // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + W'(1);
    end
  end

endmodule

// File: rtl/pl_stage_buf.sv
// Elastic pipeline-stage register: DEPTH-entry circular skid buffer with a
// valid/ready handshake on both sides, synchronous flush and occupancy count.
// in_ready depends only on registered occupancy, so a downstream stall never
// ripples combinationally back to the upstream stage.
module pl_stage_buf
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = MEM_WB_DATA_W,
  parameter int CTRL_W = MEM_WB_CTRL_W,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = ptr_width(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count_q;
  logic             push;
  logic             pop;

  // Handshake status comes straight from the occupancy register.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  // Flush overrides both sides, so neither a push nor a pop is honoured with it.
  assign push = in_valid  & in_ready  & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Head entry is presented directly; control bits are masked while invalid.
  assign out_data = mem[head].data;
  assign out_ctrl = out_valid ? mem[head].ctrl : '0;

  pl_ptr_ctr #(
    .W     (PTR_W),
    .DEPTH (DEPTH)
  ) u_head (
    .CLK  (CLK),
    .nRST (nRST),
    .clr  (flush),
    .inc  (pop),
    .ptr  (head)
  );

  pl_ptr_ctr #(
    .W     (PTR_W),
    .DEPTH (DEPTH)
  ) u_tail (
    .CLK  (CLK),
    .nRST (nRST),
    .clr  (flush),
    .inc  (push),
    .ptr  (tail)
  );

  // Occupancy: +1 on push only, -1 on pop only, held when both or neither.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage: written at the tail on push, cleared only by reset.
  // NOTE: the storage is reset here so out_data is never X after reset; flush
  // leaves it alone because out_valid/out_ctrl already hide stale entries.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[tail] <= '{data: in_data, ctrl: in_ctrl};
    end
  end

endmodule

// File: doc/pl_stage_buf.md
Name: pl_stage_buf

Overview:
- Parametrised elastic pipeline-stage register; the next generation of the fixed MEM/WB-style latch.
- Carries an opaque payload plus a kill-able control field between two pipeline stages, using a valid/ready handshake.
- Provides DEPTH entries of skid buffering, so a downstream stall does not have to propagate combinationally upstream.
- Adds synchronous flush and an occupancy count; instantiated between any pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 128, payload width (dmemload, ALU result, address, destination register, ...).
- CTRL_W, 4, control-bit width (RegWrite, MemToReg, halt, ...); forced to zero whenever output is invalid.
- DEPTH, 2, number of buffer entries; power of two, >= 1.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous kill of all buffered entries.
- in_valid  input  1  upstream has an entry.
- in_ready  output  1  buffer can accept this cycle.
- in_data  input  DATA_W  upstream payload.
- in_ctrl  input  CTRL_W  upstream control bits.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  downstream consumes head this cycle.
- out_data  output  DATA_W  head payload.
- out_ctrl  output  CTRL_W  head control bits; zero when out_valid=0.
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Storage: circular array of DEPTH entries {data, ctrl}; head and tail pointers of $clog2(DEPTH) bits (1 bit minimum); count register.
- Reset (nRST low, asynchronous):
  - head=0, tail=0, count=0.
  - Entry storage is cleared to 0.
  - Resulting outputs: out_valid=0, out_ctrl=0, out_data=0, in_ready=1, count=0.
  - A reset asserted mid-transfer discards all entries.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH). Purely registered, with no combinational path from out_ready.
- out_valid = (count != 0).
- out_data = mem[head].
- out_ctrl = out_valid ? mem[head].ctrl : 0.
- Latency: an entry pushed at edge N is visible on out_* after edge N (one cycle), provided it is at the head.
- Push: write mem[tail] <= {in_data, in_ctrl}; tail <= tail+1, wrapping modulo DEPTH.
- Pop: head <= head+1, wrapping modulo DEPTH.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, which is legal when full only if the pop happens (push is already gated by in_ready, which is 0 when full).
- Full (count=DEPTH): in_ready=0; in_valid is ignored and upstream must hold its data.
- Empty (count=0): out_valid=0; out_ready is ignored; no pointer movement.
- Flush:
  - Takes priority over push and pop in the same cycle.
  - Next state: head=0, tail=0, count=0; the entry offered on in_* that cycle is dropped.
  - Storage contents need not be cleared, because out_ctrl is masked.
- DEPTH=1 degenerates to a single valid-tagged register: in_ready = ~out_valid.
- No X on outputs after reset; the handshake inputs must never be X.

Decomposition:
- Shared package cpu_types_pkg gains typedefs for the per-stage payload structs (e.g. mem_wb_data_t, mem_wb_ctrl_t) and their widths as localparams. Instances pass $bits() of these as DATA_W/CTRL_W.
- One natural sub-module: pl_ptr_ctr, a wrap-around pointer of parameterised width with increment and synchronous clear, instantiated for head and tail.
- The count logic stays in the top-level module.

Test Plan:
- Reset then idle, DEPTH=2: hold nRST=0 and check out_valid=0, out_ctrl=0, in_ready=1, count=0; release and check these hold for 5 cycles with in_valid=0.
- Streaming: out_ready=1; push data 0x11,0x22,0x33 (ctrl=4'b0011) on consecutive cycles -> out_data shows 0x11,0x22,0x33 one cycle after each push, count stays 1, in_ready stays 1.
- Fill/stall: out_ready=0; push 0xA,0xB,0xC -> 0xA and 0xB are accepted, count=2, in_ready=0, and 0xC is held. Raise out_ready -> drains 0xA, then 0xB, then 0xC is accepted; order is preserved with no loss or duplication.
- Wrap-around: DEPTH=4; run 10 pushes interleaved with pops, with occupancy cycling 0..4 -> output sequence equals input sequence and the pointers wrap correctly.
- Flush: buffer holds 2 entries with ctrl=4'b1111; assert flush together with a push of 0xD and out_ready=1 -> next cycle count=0, out_valid=0, out_ctrl=0, and 0xD is never emitted.
- Async reset mid-operation: buffer holds 1 entry; drop nRST between edges -> outputs go to reset values immediately (before the next edge), count=0.
